// File: rtl/demlen_xuong_auto.sv
// demlen_xuong_auto
// Free-running bounce counter. It counts up from MIN_VAL to MAX_VAL, then
// down to MIN_VAL, and repeats. Neither endpoint is repeated, so one full
// period is 2*(MAX_VAL-MIN_VAL) clocks. Typical use is as a triangle-wave
// or sequence generator.
//
// Ports:
//   Clk  in   1      system clock, rising edge
//   RST  in   1      synchronous reset, active low
//   OUT  out  WIDTH  current count, taken straight from a flop
//   DIR  out  1      current direction (1 = up, 0 = down), taken straight from a flop
//
// Parameters:
//   WIDTH    counter width in bits
//   MIN_VAL  lower turn-around value (must be < MAX_VAL)
//   MAX_VAL  upper turn-around value (must be <= 2^WIDTH-1)
module demlen_xuong_auto #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic             Clk,
  input  logic             RST,
  output logic [WIDTH-1:0] OUT,
  output logic             DIR
);

  localparam logic [WIDTH-1:0] min_v = MIN_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] max_v = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] one_v = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] out_reg, out_next;
  logic             dir_reg, dir_next;
  logic [WIDTH-1:0] inc_val, dec_val;

  // These values are used only when the matching range guard holds, so
  // neither one can wrap, even with MAX_VAL = 2^WIDTH-1.
  assign inc_val = out_reg + one_v;
  assign dec_val = out_reg - one_v;

  // State register
  always_ff @(posedge Clk) begin
    if (!RST) begin
      out_reg <= min_v;
      dir_reg <= 1'b1;
    end else begin
      out_reg <= out_next;
      dir_reg <= dir_next;
    end
  end

  // Next-state logic. DIR turns on the same edge that OUT reaches an
  // endpoint. As a result, the endpoint value is emitted only once.
  always_comb begin
    out_next = out_reg;
    dir_next = dir_reg;
    if (dir_reg && (out_reg < max_v)) begin
      out_next = inc_val;
      dir_next = (inc_val != max_v);
    end else if (!dir_reg && (out_reg > min_v)) begin
      out_next = dec_val;
      dir_next = (dec_val == min_v);
    end else if (dir_reg) begin
      // Recovery: the count is already at or above the top while still
      // marked as counting up. Step back into range and count down.
      out_next = max_v - one_v;
      dir_next = 1'b0;
    end else begin
      // Recovery: the count is already at or below the bottom while
      // marked as counting down. Step back into range and count up.
      out_next = min_v + one_v;
      dir_next = 1'b1;
    end
  end

  // Outputs are driven directly from the flops.
  always_comb begin
    OUT = out_reg;
    DIR = dir_reg;
  end

endmodule

// File: tb/tb_demlen_xuong_auto.sv
module tb_demlen_xuong_auto;

  typedef struct {
    logic [3:0] a_out;
    logic       a_dir;
    logic [2:0] b_out;
    logic       b_dir;
    int         tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] a_out;
  logic       a_dir;
  logic [2:0] b_out;
  logic       b_dir;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  int   pos_a;
  int   pos_b;
  int   tag_cnt;
  logic [3:0] hist_a[$];

  // Default instance: 4 bit, 0..15, period 30
  demlen_xuong_auto dut_a (
    .Clk(clk),
    .RST(rst),
    .OUT(a_out),
    .DIR(a_dir)
  );

  // Narrow instance: 3 bit, 2..5, period 6
  demlen_xuong_auto #(
    .WIDTH(3),
    .MIN_VAL(2),
    .MAX_VAL(5)
  ) dut_b (
    .Clk(clk),
    .RST(rst),
    .OUT(b_out),
    .DIR(b_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected value at phase p of a triangle that starts at mn and spans rng.
  function automatic int tri_val(input int p, input int mn, input int rng);
    return (p <= rng) ? (mn + p) : (mn + 2 * rng - p);
  endfunction

  // Drive one edge of stimulus and queue the expected post-edge state.
  task automatic step(input logic r);
    exp_t e;
    @(negedge clk);
    rst = r;
    if (!r) begin
      pos_a = 0;
      pos_b = 0;
    end else begin
      pos_a = (pos_a + 1) % 30;
      pos_b = (pos_b + 1) % 6;
    end
    e.a_out = 4'(tri_val(pos_a, 0, 15));
    e.a_dir = (pos_a < 15);
    e.b_out = 3'(tri_val(pos_b, 2, 3));
    e.b_dir = (pos_b < 3);
    e.tag   = tag_cnt;
    tag_cnt++;
    exp_q.push_back(e);
  endtask

  // Monitor: one check per edge, fed from the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (a_out !== e.a_out || a_dir !== e.a_dir) begin
          fails++;
          $display("FAIL a_state #%0d: got out=%0d dir=%0b, want out=%0d dir=%0b",
                   e.tag, a_out, a_dir, e.a_out, e.a_dir);
        end else begin
          $display("[TB] #%0d a out=%0d dir=%0b ok", e.tag, a_out, a_dir);
        end
        tests++;
        if (b_out !== e.b_out || b_dir !== e.b_dir) begin
          fails++;
          $display("FAIL b_state #%0d: got out=%0d dir=%0b, want out=%0d dir=%0b",
                   e.tag, b_out, b_dir, e.b_out, e.b_dir);
        end
        // Periodicity check on the default instance, restarted by each reset.
        if (!rst) begin
          hist_a.delete();
        end else begin
          hist_a.push_back(a_out);
          if (hist_a.size() > 30) begin
            tests++;
            if (hist_a[hist_a.size()-1] !== hist_a[hist_a.size()-31]) begin
              fails++;
              $display("FAIL period_a #%0d: got %0d, want %0d (30 cycles earlier)",
                       e.tag, hist_a[hist_a.size()-1], hist_a[hist_a.size()-31]);
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    tests   = 0;
    fails   = 0;
    pos_a   = 0;
    pos_b   = 0;
    tag_cnt = 0;
    rst     = 1'b0;

    // Hold reset for 10 edges.
    for (int i = 0; i < 10; i++) step(1'b0);
    // Release the reset and run well past three periods. This covers the up ramp, the top turn, the down ramp and the bottom turn.
    for (int i = 0; i < 100; i++) step(1'b1);

    // Advance to OUT=9 on the down sweep (phase 21), then apply reset for one edge.
    guard = 0;
    while (pos_a != 21 && guard < 40) begin
      step(1'b1);
      guard++;
    end
    tests++;
    if (pos_a != 21) begin
      fails++;
      $display("FAIL reach_down9: got phase %0d, want 21", pos_a);
    end
    step(1'b0);
    for (int i = 0; i < 12; i++) step(1'b1);

    // Apply a reset in the middle of an up sweep, then resume counting.
    step(1'b0);
    for (int i = 0; i < 8; i++) step(1'b1);

    // Let the monitor drain the queue. The wait is bounded.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
